mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: MAX_WAIT, default 255, maximum cycles one memory access may stay pending before it is declared an error (1..255).
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 i_req  in  1  instruction-fetch request.
REQ-006 i_addr  in  32  fetch address (PC).
REQ-007 d_ren  in  1  data load request.
REQ-008 d_wen  in  1  data store request.
REQ-009 d_addr  in  32  load/store address.
REQ-010 d_wdata  in  32  store data.
REQ-011 d_be  in  4  store byte enables (SB/SH/SW).
REQ-012 m_busy  in  1  memory busy; low in a driven cycle means the access completes this cycle.
REQ-013 m_rdata  in  32  memory read data, valid when m_busy is low.
REQ-014 m_ren, m_wen  out  1 each  memory read/write strobes.
REQ-015 m_addr  out  32; m_wdata  out  32; m_be  out  4  memory bus.
REQ-016 i_ready  out  1  one-cycle fetch-complete pulse; i_rdata  out  32  fetched instruction.
REQ-017 d_ready  out  1  one-cycle data-complete pulse; d_rdata  out  32  load data.
REQ-018 err  out  1  sticky timeout flag.

Function
REQ-019 States: IDLE, IACC, DACC, ERROR; all outputs registered or decoded from the state only.
REQ-020 IDLE: (d_ren|d_wen) -> DACC; else i_req -> IACC; else stay. Data beats fetch when both are asserted on the same edge.
REQ-021 A requester whose ready is high in the current cycle SHALL be ignored by IDLE on that edge (no re-issue of a consumed request).
REQ-022 On entering IACC/DACC the address, wdata, be and type SHALL be latched; the bus is driven from the latches, and later input changes have no effect.
REQ-023 IACC drives m_ren=1, m_wen=0, m_be=4'hF, m_addr=latched i_addr.
REQ-024 DACC drives m_wen=1 if d_wen was latched (d_wen wins over d_ren when both are high); otherwise it drives m_ren=1; m_be=latched d_be on writes, 4'hF on reads.
REQ-025 In IACC/DACC, m_busy=0 at a rising edge -> capture m_rdata into i_rdata (IACC) or d_rdata (DACC read), pulse the matching ready for exactly one cycle, and go to IDLE.
REQ-026 d_rdata SHALL be unchanged on a store; i_rdata/d_rdata hold their value until the next completion of their own type.
REQ-027 Minimum latency: request sampled at edge t, completion sampled at t+1, ready high during the cycle after t+1 (2 cycles).
REQ-028 Dropping a request mid-access SHALL NOT abort it; the access completes and the ready pulse is still issued.
REQ-029 An 8-bit wait counter SHALL clear on entering IACC/DACC and increment each edge with m_busy=1; when it reaches MAX_WAIT with m_busy still 1, go to ERROR.
REQ-030 ERROR: all strobes 0, no ready pulses, err=1; only rst exits ERROR.
REQ-031 m_ren and m_wen SHALL never be high together; both are 0 in IDLE and ERROR.

Reset
REQ-032 rst high at an edge -> state IDLE, all strobes 0, m_addr/m_wdata/i_rdata/d_rdata=0, m_be=0, i_ready=d_ready=0, err=0, counter=0; this takes precedence over every transition, including mid-access (the access is abandoned with no ready pulse).

Verification
REQ-033 Fetch: i_req=1, i_addr=0x0000_0004, m_busy=0, m_rdata=0x3E80_0093 -> m_ren=1 for one cycle at addr 0x4, then i_ready pulse with i_rdata=0x3E80_0093 two cycles after the request.
REQ-034 Collision: i_req=1 and d_ren=1 (d_addr=0x100) on the same edge, m_rdata=0x0000_03E8 -> DACC first, d_ready with d_rdata=0x3E8, then IACC, then i_ready; no cycle has both strobes high.
REQ-035 Store with wait: d_wen=1, d_addr=0x200, d_wdata=0xDEAD_BEEF, d_be=4'b0011, m_busy=1 for 3 cycles -> bus held stable for 4 cycles, d_ready pulses once, d_rdata unchanged.
REQ-036 Timeout: MAX_WAIT=4, i_req=1, m_busy held at 1 -> ERROR after 4 busy edges, err=1, strobes 0, no i_ready; assert rst -> err=0 and state IDLE.
REQ-037 Reset mid-access: rst pulsed during DACC -> no d_ready, all outputs at their reset values on the next cycle, and a later i_req is served normally.
REQ-038 Held request: i_req held high across a completion -> exactly one access per ready pulse, and the next access starts on the edge after the ready cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory bus between an instruction-fetch
// requester and a load/store requester. Data accesses win over fetches, every
// access is latched and driven from registers, and a stalled access that stays
// busy for MAX_WAIT edges locks the block into a sticky error state.
module mem_arbiter #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic        d_ren,
    input  logic        d_wen,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    input  logic        m_busy,
    input  logic [31:0] m_rdata,
    output logic        m_ren,
    output logic        m_wen,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_be,
    output logic        i_ready,
    output logic [31:0] i_rdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE,
        IACC,
        DACC,
        ERROR
    } state_t;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    state_t      state_q;
    logic [7:0]  wait_q;
    logic [7:0]  wait_d;
    logic        m_ren_q;
    logic        m_wen_q;
    logic [31:0] m_addr_q;
    logic [31:0] m_wdata_q;
    logic [3:0]  m_be_q;
    logic        i_ready_q;
    logic [31:0] i_rdata_q;
    logic        d_ready_q;
    logic [31:0] d_rdata_q;
    logic        err_q;

    logic        d_take;
    logic        i_take;
    logic        timeout;

    // Request qualification: a requester just served this cycle is not re-issued.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        d_take  = 1'b0;
        i_take  = 1'b0;
        wait_d  = wait_q + 8'd1;
        d_take  = (d_ren | d_wen) & ~d_ready_q;
        i_take  = i_req & ~i_ready_q;
        timeout = (wait_d == MAX_WAIT_C);
    end

    // Arbitration FSM with all bus and response outputs registered.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q   <= IDLE;
            wait_q    <= 8'd0;
            m_ren_q   <= 1'b0;
            m_wen_q   <= 1'b0;
            m_addr_q  <= 32'd0;
            m_wdata_q <= 32'd0;
            m_be_q    <= 4'd0;
            i_ready_q <= 1'b0;
            i_rdata_q <= 32'd0;
            d_ready_q <= 1'b0;
            d_rdata_q <= 32'd0;
            err_q     <= 1'b0;
        end else begin
            // Ready outputs are single-cycle pulses unless set again below.
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (d_take) begin
                        // Store wins when both load and store are requested.
                        state_q   <= DACC;
                        wait_q    <= 8'd0;
                        m_addr_q  <= d_addr;
                        m_wdata_q <= d_wdata;
                        m_wen_q   <= d_wen;
                        m_ren_q   <= ~d_wen;
                        m_be_q    <= d_wen ? d_be : 4'hF;
                    end else if (i_take) begin
                        state_q  <= IACC;
                        wait_q   <= 8'd0;
                        m_addr_q <= i_addr;
                        m_wen_q  <= 1'b0;
                        m_ren_q  <= 1'b1;
                        m_be_q   <= 4'hF;
                    end
                end
                IACC, DACC: begin
                    if (!m_busy) begin
                        state_q <= IDLE;
                        m_ren_q <= 1'b0;
                        m_wen_q <= 1'b0;
                        if (state_q == IACC) begin
                            i_rdata_q <= m_rdata;
                            i_ready_q <= 1'b1;
                        end else begin
                            // The latched write strobe marks a store: load data is left untouched.
                            if (!m_wen_q) begin
                                d_rdata_q <= m_rdata;
                            end
                            d_ready_q <= 1'b1;
                        end
                    end else if (timeout) begin
                        state_q <= ERROR;
                        m_ren_q <= 1'b0;
                        m_wen_q <= 1'b0;
                        err_q   <= 1'b1;
                    end else begin
                        wait_q <= wait_d;
                    end
                end
                ERROR: begin
                    // Only reset leaves this state; strobes are already low.
                    m_ren_q <= 1'b0;
                    m_wen_q <= 1'b0;
                    err_q   <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign m_ren   = m_ren_q;
    assign m_wen   = m_wen_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign m_be    = m_be_q;
    assign i_ready = i_ready_q;
    assign i_rdata = i_rdata_q;
    assign d_ready = d_ready_q;
    assign d_rdata = d_rdata_q;
    assign err     = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus a randomized two-requester run.
// Expected responses are queued at issue time from a word-addressed memory
// model; a monitor pops and compares on every ready pulse.
module tb_mem_arbiter;

    localparam int unsigned MAX_WAIT = 4;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_ren;
    logic        d_wen;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        m_busy;
    logic [31:0] m_rdata;
    logic        m_ren;
    logic        m_wen;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_be;
    logic        i_ready;
    logic [31:0] i_rdata;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        err;

    mem_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk    (clk),
        .rst    (rst),
        .i_req  (i_req),
        .i_addr (i_addr),
        .d_ren  (d_ren),
        .d_wen  (d_wen),
        .d_addr (d_addr),
        .d_wdata(d_wdata),
        .d_be   (d_be),
        .m_busy (m_busy),
        .m_rdata(m_rdata),
        .m_ren  (m_ren),
        .m_wen  (m_wen),
        .m_addr (m_addr),
        .m_wdata(m_wdata),
        .m_be   (m_be),
        .i_ready(i_ready),
        .i_rdata(i_rdata),
        .d_ready(d_ready),
        .d_rdata(d_rdata),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- memory: responder copy and reference copy ----------------
    logic [31:0] slave_mem [int unsigned];
    logic [31:0] ref_mem   [int unsigned];
    logic [31:0] i_exp [$];
    logic [31:0] d_exp [$];
    logic [31:0] last_load;

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] slave_rd(input logic [31:0] a);
        return slave_mem.exists(a) ? slave_mem[a] : init_val(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        slave_mem[a] = v;
        ref_mem[a]   = v;
    endtask

    // ---------------- memory responder ----------------
    int          fixed_wait = 0;   // <0 selects a random 0..3 busy cycles per access
    int          wait_left  = 0;
    bit          in_acc     = 0;
    logic        prev_strobe = 0, prev_busy = 1, prev_rst = 1, prev_wen = 0, prev_ren = 0;
    logic [31:0] prev_addr = 0, prev_wdata = 0;
    logic [3:0]  prev_be = 0;

    initial begin
        m_busy  = 1'b1;
        m_rdata = 32'd0;
        forever begin
            @(negedge clk);
            // A write completes at the edge where it was driven and not busy.
            if (prev_strobe && prev_wen && !prev_busy && !prev_rst)
                slave_mem[prev_addr] = merge(slave_rd(prev_addr), prev_wdata, prev_be);
            if (m_ren || m_wen) begin
                check("strobe_excl", {31'd0, m_ren & m_wen}, 32'd0);
                if (m_ren) check("read_be", {28'd0, m_be}, 32'hF);
                if (in_acc) begin
                    check("bus_stable", {31'd0, (m_addr == prev_addr) && (m_wdata == prev_wdata) &&
                          (m_be == prev_be) && (m_ren == prev_ren) && (m_wen == prev_wen)}, 32'd1);
                end else begin
                    in_acc    = 1;
                    wait_left = (fixed_wait < 0) ? int'($urandom_range(0, 3)) : fixed_wait;
                end
                m_busy = (wait_left > 0);
                if (wait_left > 0) wait_left--;
                m_rdata = m_busy ? $urandom : slave_rd(m_addr);
            end else begin
                in_acc  = 0;
                m_busy  = 1'($urandom_range(0, 1));
                m_rdata = $urandom;
            end
            prev_strobe = m_ren | m_wen;
            prev_ren    = m_ren;
            prev_wen    = m_wen;
            prev_busy   = m_busy;
            prev_rst    = rst;
            prev_addr   = m_addr;
            prev_wdata  = m_wdata;
            prev_be     = m_be;
        end
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (i_ready) begin
            if (i_exp.size() == 0) check("i_ready_unexpected", 32'd1, 32'd0);
            else check("i_rdata", i_rdata, i_exp.pop_front());
        end
        if (d_ready) begin
            if (d_exp.size() == 0) check("d_ready_unexpected", 32'd1, 32'd0);
            else check("d_rdata", d_rdata, d_exp.pop_front());
        end
    end

    // Global watchdog.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, queue its expectation, hold it until its ready pulse.
    task automatic do_req(input bit is_d, input bit wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be);
        bit seen;
        seen = 0;
        if (is_d) begin
            d_addr = a; d_wdata = wd; d_be = be; d_wen = wr; d_ren = ~wr;
            if (wr) begin
                ref_mem[a] = merge(ref_rd(a), wd, be);
                d_exp.push_back(last_load);
            end else begin
                last_load = ref_rd(a);
                d_exp.push_back(last_load);
            end
        end else begin
            i_addr = a; i_req = 1'b1;
            i_exp.push_back(ref_rd(a));
        end
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            seen = is_d ? d_ready : i_ready;
        end
        if (!seen) check("req_timeout", 32'd1, 32'd0);
        tick();
        i_req = 1'b0; d_ren = 1'b0; d_wen = 1'b0;
    endtask

    // ---------------- main stimulus ----------------
    initial begin
        logic [8:0]  ren9, rdy9;
        logic [6:0]  ren7, err7;
        logic [5:0]  rdy6;
        int          first, d_at, i_at, both, wen_n, extra;
        bit          f_act, d_act;
        int          f_age, d_age, kind;
        logic [31:0] a, wd;
        logic [3:0]  be;
        logic [3:0]  be_tab [7];

        be_tab = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
        rst = 1'b1; i_req = 0; i_addr = 0; d_ren = 0; d_wen = 0;
        d_addr = 0; d_wdata = 0; d_be = 0; last_load = 0;
        repeat (2) tick();
        @(negedge clk);
        check("rst_flags",   {27'd0, m_ren, m_wen, i_ready, d_ready, err}, 32'd0);
        check("rst_m_addr",  m_addr, 32'd0);
        check("rst_m_wdata", m_wdata, 32'd0);
        check("rst_m_be",    {28'd0, m_be}, 32'd0);
        check("rst_i_rdata", i_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        tick();
        rst = 1'b0;

        // Single fetch with zero wait: strobe one cycle, ready two cycles after request.
        fixed_wait = 0;
        preload(32'h4, 32'h3E80_0093);
        i_req = 1'b1; i_addr = 32'h4;
        i_exp.push_back(32'h3E80_0093);
        tick();
        i_req = 1'b0; i_addr = 32'hFFFF_FFF0;
        @(negedge clk);
        check("fetch_strobes", {30'd0, m_ren, m_wen}, 32'd2);
        check("fetch_addr", m_addr, 32'h4);
        check("fetch_be", {28'd0, m_be}, 32'hF);
        check("fetch_early_ready", {31'd0, i_ready}, 32'd0);
        tick();
        @(negedge clk);
        check("fetch_ready", {30'd0, i_ready, m_ren}, 32'd2);
        check("fetch_rdata", i_rdata, 32'h3E80_0093);
        tick();
        @(negedge clk);
        check("fetch_pulse_len", {31'd0, i_ready}, 32'd0);

        // Collision: data first, then fetch, never both strobes together.
        preload(32'h100, 32'h0000_03E8);
        preload(32'h8, 32'h0BAD_F00D);
        i_req = 1'b1; i_addr = 32'h8; d_ren = 1'b1; d_addr = 32'h100;
        d_exp.push_back(32'h0000_03E8); i_exp.push_back(32'h0BAD_F00D);
        last_load = 32'h0000_03E8;
        first = 0; d_at = -1; i_at = -1; both = 0;
        tick();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (m_ren && m_wen) both++;
            if (first == 0 && (m_ren || m_wen)) first = (m_addr == 32'h100) ? 1 : 2;
            if (d_ready && d_at < 0) d_at = c;
            if (i_ready && i_at < 0) i_at = c;
            tick();
            if (d_at == c) d_ren = 1'b0;
            if (i_at == c) i_req = 1'b0;
        end
        check("coll_first_is_data", first, 32'd1);
        check("coll_d_ready_cycle", d_at, 32'd1);
        check("coll_i_ready_cycle", i_at, 32'd3);
        check("coll_both_strobes", both, 32'd0);

        // Held fetch request: one access per ready pulse, restart after ready cycle.
        preload(32'hC, 32'h0000_0013);
        repeat (3) i_exp.push_back(32'h0000_0013);
        i_req = 1'b1; i_addr = 32'hC;
        tick();
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            ren9[c] = m_ren;
            rdy9[c] = i_ready;
            tick();
            if (c == 7) i_req = 1'b0;
        end
        extra = 0;
        repeat (3) begin
            @(negedge clk);
            if (m_ren) extra++;
            tick();
        end
        check("held_ren_pattern", {23'd0, ren9}, 32'b001001001);
        check("held_rdy_pattern", {23'd0, rdy9}, 32'b010010010);
        check("held_no_extra", extra, 32'd0);

        // Store with three busy cycles, request dropped right after it is taken.
        fixed_wait = 3;
        d_wen = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
        ref_mem[32'h200] = merge(ref_rd(32'h200), 32'hDEAD_BEEF, 4'b0011);
        d_exp.push_back(last_load);
        tick();
        d_wen = 1'b0; d_addr = 32'hFFF0; d_wdata = 32'd0; d_be = 4'hF;
        wen_n = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (m_wen && !m_ren && m_addr == 32'h200 && m_wdata == 32'hDEAD_BEEF && m_be == 4'b0011)
                wen_n++;
            rdy6[c] = d_ready;
            tick();
        end
        check("store_bus_cycles", wen_n, 32'd4);
        check("store_ready_pattern", {26'd0, rdy6}, 32'b010000);
        check("store_d_rdata_kept", d_rdata, 32'h0000_03E8);
        fixed_wait = 0;
        do_req(1'b1, 1'b0, 32'h200, 32'd0, 4'hF);

        // Timeout: four busy edges lead to a sticky error.
        fixed_wait = 1000;
        i_req = 1'b1; i_addr = 32'h40;
        tick();
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            ren7[c] = m_ren | m_wen;
            err7[c] = err;
            tick();
        end
        check("tmo_strobe_pattern", {25'd0, ren7}, 32'b0001111);
        check("tmo_err_pattern", {25'd0, err7}, 32'b1110000);
        rst = 1'b1; i_req = 1'b0;
        tick();
        rst = 1'b0; last_load = 32'd0;
        @(negedge clk);
        check("tmo_rst_clears", {29'd0, err, m_ren, m_wen}, 32'd0);
        fixed_wait = 0;
        do_req(1'b0, 1'b0, 32'h40, 32'd0, 4'hF);

        // Reset in the middle of a load: abandoned, no ready, outputs back to reset.
        preload(32'h44, 32'h1234_5678);
        fixed_wait = 1000;
        d_ren = 1'b1; d_addr = 32'h300;
        tick();
        d_ren = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; last_load = 32'd0;
        @(negedge clk);
        check("midrst_flags",   {27'd0, m_ren, m_wen, i_ready, d_ready, err}, 32'd0);
        check("midrst_m_addr",  m_addr, 32'd0);
        check("midrst_m_wdata", m_wdata, 32'd0);
        check("midrst_m_be",    {28'd0, m_be}, 32'd0);
        check("midrst_i_rdata", i_rdata, 32'd0);
        check("midrst_d_rdata", d_rdata, 32'd0);
        fixed_wait = 0;
        do_req(1'b0, 1'b0, 32'h44, 32'd0, 4'hF);

        // Randomized traffic from both requesters with random memory stalls.
        fixed_wait = -1;
        f_act = 0; d_act = 0; f_age = 0; d_age = 0;
        for (int cyc = 0; cyc < 3040; cyc++) begin
            if (f_act && i_ready) begin f_act = 0; i_req = 1'b0; end
            if (d_act && d_ready) begin d_act = 0; d_ren = 1'b0; d_wen = 1'b0; end
            if (f_act && ++f_age > 40) begin
                check("rand_fetch_hang", 32'd1, 32'd0); f_act = 0; i_req = 1'b0;
            end
            if (d_act && ++d_age > 40) begin
                check("rand_data_hang", 32'd1, 32'd0); d_act = 0; d_ren = 1'b0; d_wen = 1'b0;
            end
            if (cyc < 3000 && !f_act && $urandom_range(0, 2) == 0) begin
                a = {20'd0, 10'($urandom), 2'b00};
                i_addr = a; i_req = 1'b1;
                i_exp.push_back(ref_rd(a));
                f_act = 1; f_age = 0;
            end
            if (cyc < 3000 && !d_act && $urandom_range(0, 2) == 0) begin
                a    = {16'h0001, 4'd0, 10'($urandom), 2'b00};
                wd   = $urandom;
                be   = be_tab[$urandom_range(0, 6)];
                kind = int'($urandom_range(0, 3));
                d_addr = a; d_wdata = wd; d_be = be;
                d_ren  = (kind != 2);
                d_wen  = (kind >= 2);
                if (kind >= 2) begin
                    ref_mem[a] = merge(ref_rd(a), wd, be);
                    d_exp.push_back(last_load);
                end else begin
                    last_load = ref_rd(a);
                    d_exp.push_back(last_load);
                end
                d_act = 1; d_age = 0;
            end
            tick();
        end
        repeat (5) tick();
        check("i_exp_drained", i_exp.size(), 32'd0);
        check("d_exp_drained", d_exp.size(), 32'd0);
        check("err_clear_end", {31'd0, err}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
